// File: rtl/multu_seq.sv
// Iterative shift-add unsigned multiplier for the HiLo stage: one multiplier bit per cycle,
// WIDTH cycles per product, then a single-cycle last pulse carrying the MADDU accumulate flag.
module multu_seq #(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 flush,
    input  logic                 add_in,
    input  logic [WIDTH-1:0]     src_a,
    input  logic [WIDTH-1:0]     src_b,
    output logic                 busy,
    output logic [2*WIDTH-1:0]   MultuAns,
    output logic                 last,
    output logic                 AddSignal
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state;
    logic [WIDTH-1:0]   mcand;
    logic [WIDTH-1:0]   mplier;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] accNext;
    logic [WIDTH:0]     upperSum;
    logic [CW-1:0]      count;

    // The carry out of the upper-half add becomes the new MSB as the accumulator shifts right.
    always_comb begin
        upperSum = {1'b0, acc[2*WIDTH-1:WIDTH]} + (mplier[0] ? {1'b0, mcand} : '0);
        accNext  = {upperSum, acc[WIDTH-1:1]};
    end

    // NOTE: state and outputs are updated with <= so every register sees pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            mcand     <= '0;
            mplier    <= '0;
            acc       <= '0;
            count     <= '0;
            MultuAns  <= '0;
            AddSignal <= 1'b0;
            busy      <= 1'b0;
            last      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    last <= 1'b0;
                    if (start && !flush) begin
                        mcand     <= src_a;
                        mplier    <= src_b;
                        acc       <= '0;
                        count     <= '0;
                        AddSignal <= add_in;
                        busy      <= 1'b1;
                        state     <= RUN;
                    end
                end
                RUN: begin
                    if (flush) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        acc    <= accNext;
                        mplier <= mplier >> 1;
                        count  <= count + 1'b1;
                        if (count == CW'(WIDTH - 1)) begin
                            MultuAns <= accNext;
                            last     <= 1'b1;
                            state    <= DONE;
                        end
                    end
                end
                DONE: begin
                    // The result is already committed here, so a flush cannot retract it.
                    last  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    last  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
